// File: rtl/rib_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rib_arbiter_pkg : shared master indices, slave region codes and helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rib_arbiter_pkg;

  localparam int NUM_M = 4;
  localparam int NUM_S = 3;

  localparam int M_CORE_DATA  = 0;
  localparam int M_CORE_FETCH = 1;
  localparam int M_SPARE      = 2;
  localparam int M_JTAG       = 3;

  localparam logic [3:0] REGION_ROM    = 4'h0;
  localparam logic [3:0] REGION_RAM    = 4'h1;
  localparam logic [3:0] REGION_PERIPH = 4'h2;

  localparam int BURST_MAX_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_M; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Rotation ring of the non-JTAG masters: position 0..2 -> m0, m2, m1
  function automatic logic [1:0] rr_master(input logic [1:0] pos);
    case (pos)
      2'd0:    return 2'(M_CORE_DATA);
      2'd1:    return 2'(M_SPARE);
      default: return 2'(M_CORE_FETCH);
    endcase
  endfunction

  function automatic logic [1:0] rr_pos(input logic [1:0] idx);
    case (idx)
      2'(M_CORE_DATA): return 2'd0;
      2'(M_SPARE):     return 2'd1;
      default:         return 2'd2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rib_arbiter_if.sv
// ---------------------------------------------------------------------------
// rib_arbiter_if : master-side and slave-side bus bundle of the arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rib_arbiter_if
  import rib_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [NUM_M-1:0]             m_req_i;
  logic [NUM_M-1:0][ADDR_W-1:0] m_addr_i;
  logic [NUM_M-1:0][DATA_W-1:0] m_data_i;
  logic [NUM_M-1:0]             m_we_i;
  logic [NUM_M-1:0][DATA_W-1:0] m_data_o;

  logic [NUM_S-1:0][ADDR_W-1:0] s_addr_o;
  logic [NUM_S-1:0][DATA_W-1:0] s_data_o;
  logic [NUM_S-1:0]             s_we_o;
  logic [NUM_S-1:0][DATA_W-1:0] s_data_i;

  logic [NUM_M-1:0]             gnt_o;
  logic                         hold_flag_o;
  logic                         err_o;

  // The arbiter itself sits on the slave side of the masters' requests
  modport slave (
    input  m_req_i, m_addr_i, m_data_i, m_we_i, s_data_i,
    output m_data_o, s_addr_o, s_data_o, s_we_o, gnt_o, hold_flag_o, err_o
  );

  modport master (
    output m_req_i, m_addr_i, m_data_i, m_we_i, s_data_i,
    input  m_data_o, s_addr_o, s_data_o, s_we_o, gnt_o, hold_flag_o, err_o
  );

endinterface

`default_nettype wire

// File: rtl/rib_prio_enc.sv
// ---------------------------------------------------------------------------
// rib_prio_enc : one-hot winner from requests minus exclude mask (RIB_RR_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rib_prio_enc
  import rib_arbiter_pkg::*;
(
`ifdef RIB_RR_EN
  input  logic [1:0]       rr_ptr_i,
`endif
  input  logic [NUM_M-1:0] req_i,
  input  logic [NUM_M-1:0] excl_i,
  output logic [NUM_M-1:0] gnt_o
);

  logic [NUM_M-1:0] cand;

`ifdef RIB_RR_EN
  logic [2:0] pos_sum;
  logic [1:0] pos;
  logic [1:0] idx;
  logic       found;
`endif

  always_comb begin
    gnt_o = '0;
    cand  = req_i & ~excl_i;
`ifdef RIB_RR_EN
    pos_sum = 3'd0;
    pos     = 2'd0;
    idx     = 2'd0;
    found   = 1'b0;
    if (cand[M_JTAG]) begin
      gnt_o[M_JTAG] = 1'b1;
    end else begin
      // Walk the ring starting at the pointer; first requester wins
      for (int k = 0; k < 3; k++) begin
        pos_sum = {1'b0, rr_ptr_i} + 3'(k);
        pos     = (pos_sum >= 3'd3) ? 2'(pos_sum - 3'd3) : pos_sum[1:0];
        idx     = rr_master(pos);
        if (!found && cand[idx]) begin
          gnt_o[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
`else
    if (cand[M_JTAG])              gnt_o[M_JTAG]       = 1'b1;
    else if (cand[M_CORE_DATA])    gnt_o[M_CORE_DATA]  = 1'b1;
    else if (cand[M_SPARE])        gnt_o[M_SPARE]      = 1'b1;
    else if (cand[M_CORE_FETCH])   gnt_o[M_CORE_FETCH] = 1'b1;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/rib_arbiter.sv
// ---------------------------------------------------------------------------
// rib_arbiter : 4-master / 3-slave bus arbiter with burst limit and decode;
//               define RIB_RR_EN for round-robin among m0/m2/m1
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  rib_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  state_t           state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_M-1:0] winner;
  logic             new_grant;
  logic             busy;
  logic             cur_req;
  logic             req_other;
  logic             at_max;
  logic             force_sw;

  logic [1:0]        gidx;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        region;
  logic [NUM_S-1:0]  slave_sel;
  logic [DATA_W-1:0] rdata;

`ifdef RIB_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] new_pos;
`endif

  assign busy      = (state_q == ST_BUSY);
  assign cur_req   = |(bus.m_req_i & gnt_q);
  assign req_other = |(bus.m_req_i & ~gnt_q);
  assign at_max    = (cnt_q >= CNT_MAX);
  // Burst exhausted while someone waits: current master loses the bus next edge
  assign force_sw  = busy & cur_req & at_max & req_other;

  rib_prio_enc u_prio_enc (
`ifdef RIB_RR_EN
    .rr_ptr_i (rr_ptr_q),
`endif
    .req_i    (bus.m_req_i),
    .excl_i   (gnt_q),
    .gnt_o    (winner)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    new_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.m_req_i) begin
          state_d   = ST_BUSY;
          gnt_d     = winner;
          cnt_d     = CNT_W'(1);
          new_grant = 1'b1;
        end
      end
      default: begin
        if (cur_req && !at_max) begin
          cnt_d = cnt_q + 1'b1;
        end else if (req_other) begin
          gnt_d     = winner;
          cnt_d     = CNT_W'(1);
          new_grant = 1'b1;
        end else if (!cur_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

`ifdef RIB_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    new_pos  = rr_pos(oh_to_idx(gnt_d));
    if (new_grant && !gnt_d[M_JTAG]) begin
      rr_ptr_d = (new_pos == 2'd2) ? 2'd0 : new_pos + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 2'd0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gidx     = oh_to_idx(gnt_q);
  assign sel_addr = bus.m_addr_i[gidx];
  assign region   = sel_addr[ADDR_W-1 -: 4];

  always_comb begin
    slave_sel    = '0;
    slave_sel[0] = busy && (region == REGION_ROM);
    slave_sel[1] = busy && (region == REGION_RAM);
    slave_sel[2] = busy && (region == REGION_PERIPH);
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_S; k++) begin
      bus.s_addr_o[k] = slave_sel[k] ? sel_addr : '0;
      bus.s_data_o[k] = slave_sel[k] ? bus.m_data_i[gidx] : '0;
      bus.s_we_o[k]   = slave_sel[k] & bus.m_we_i[gidx] & cur_req & ~force_sw;
      if (slave_sel[k]) rdata = bus.s_data_i[k];
    end
    for (int n = 0; n < NUM_M; n++) begin
      bus.m_data_o[n] = gnt_q[n] ? rdata : '0;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.err_o       = busy & cur_req & ~(|slave_sel);
  assign bus.hold_flag_o = bus.m_req_i[M_CORE_FETCH] & ~(busy & gnt_q[M_CORE_FETCH]);

endmodule

`default_nettype wire

// File: tb/tb_rib_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rib_arbiter : directed scenarios plus randomized traffic vs reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rib_arbiter;
  import rib_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rib_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: granted master (-1 idle), burst length, RR order
  int mg;
  int mcnt;
  int rr_q[$];

  function automatic int pick(input logic [3:0] r, input int excl);
    int ord[3];
    if (r[3] && excl != 3) return 3;
`ifdef RIB_RR_EN
    foreach (rr_q[i]) if (r[rr_q[i]] && rr_q[i] != excl) return rr_q[i];
`else
    ord = '{0, 2, 1};
    foreach (ord[i]) if (r[ord[i]] && ord[i] != excl) return ord[i];
`endif
    return -1;
  endfunction

  task automatic model_grant(input int w);
    mg   = w;
    mcnt = 1;
`ifdef RIB_RR_EN
    if (w != 3) begin
      foreach (rr_q[i]) if (rr_q[i] == w) begin rr_q.delete(i); break; end
      rr_q.push_back(w);
    end
`endif
  endtask

  task automatic model_advance(input logic [3:0] r);
    int w;
    if (mg < 0) begin
      w = pick(r, -1);
      if (w >= 0) model_grant(w);
    end else if (r[mg] && mcnt < BM) begin
      mcnt++;
    end else begin
      w = pick(r, mg);
      if (w >= 0) model_grant(w);
      else if (!r[mg]) begin mg = -1; mcnt = 0; end
    end
  endtask

  task automatic clear_inputs();
    bus.m_req_i  = '0;
    bus.m_addr_i = '0;
    bus.m_data_i = '0;
    bus.m_we_i   = '0;
    bus.s_data_i = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.m_req_i = 4'b0011;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
    checks++; if (bus.s_we_o !== 3'b000 || bus.s_addr_o !== '0 || bus.s_data_o !== '0) begin
      failures++; $display("FAIL reset_slaves we=%b addr=%h data=%h exp=0", bus.s_we_o, bus.s_addr_o, bus.s_data_o); end
    checks++; if (bus.m_data_o !== '0) begin failures++; $display("FAIL reset_mdata got=%h exp=0", bus.m_data_o); end
    checks++; if (bus.hold_flag_o !== 1'b1) begin failures++; $display("FAIL reset_hold got=%b exp=1", bus.hold_flag_o); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_m1_read();
    apply_reset();
    bus.m_req_i     = 4'b0010;
    bus.m_addr_i[1] = 32'h0000_0010;
    bus.s_data_i[0] = 32'hCAFE_0001;
    #1;
    checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL m1rd_latency gnt got=%b exp=0000", bus.gnt_o); end
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL m1rd_gnt got=%b exp=0010", bus.gnt_o); end
    checks++; if (bus.s_addr_o[0] !== 32'h10) begin failures++; $display("FAIL m1rd_s0addr got=%h exp=00000010", bus.s_addr_o[0]); end
    checks++; if (bus.m_data_o[1] !== 32'hCAFE_0001) begin failures++; $display("FAIL m1rd_data got=%h exp=cafe0001", bus.m_data_o[1]); end
    checks++; if (bus.hold_flag_o !== 1'b0) begin failures++; $display("FAIL m1rd_hold got=%b exp=0", bus.hold_flag_o); end
    bus.m_req_i = 4'b0000;
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL m1rd_idle gnt got=%b exp=0000", bus.gnt_o); end
  endtask

  task automatic test_m0_write();
    apply_reset();
    bus.m_req_i     = 4'b0011;
    bus.m_addr_i[0] = 32'h1000_0004;
    bus.m_data_i[0] = 32'hDEAD_BEEF;
    bus.m_we_i[0]   = 1'b1;
    bus.m_addr_i[1] = 32'h0000_0010;
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL m0wr_gnt got=%b exp=0001", bus.gnt_o); end
    checks++; if (bus.s_we_o !== 3'b010) begin failures++; $display("FAIL m0wr_we got=%b exp=010", bus.s_we_o); end
    checks++; if (bus.s_data_o[1] !== 32'hDEAD_BEEF || bus.s_addr_o[1] !== 32'h1000_0004) begin
      failures++; $display("FAIL m0wr_s1 data=%h addr=%h exp=deadbeef/10000004", bus.s_data_o[1], bus.s_addr_o[1]); end
    checks++; if (bus.hold_flag_o !== 1'b1) begin failures++; $display("FAIL m0wr_hold got=%b exp=1", bus.hold_flag_o); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_burst_limit();
    apply_reset();
    bus.m_req_i     = 4'b0011;
    bus.m_addr_i[0] = 32'h1000_0000;
    bus.m_we_i[0]   = 1'b1;
    bus.m_addr_i[1] = 32'h0000_0020;
    for (int i = 1; i <= BM; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL burst_m0 cyc=%0d gnt got=%b exp=0001", i, bus.gnt_o); end
      checks++; if (bus.s_we_o[1] !== (i < BM)) begin
        failures++; $display("FAIL burst_we cyc=%0d got=%b exp=%b", i, bus.s_we_o[1], (i < BM)); end
    end
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL burst_switch gnt got=%b exp=0010", bus.gnt_o); end
    bus.m_req_i[1] = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL burst_regrant gnt got=%b exp=0001", bus.gnt_o); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    apply_reset();
    bus.m_req_i     = 4'b1000;
    bus.m_addr_i[3] = 32'h5000_0000;
    bus.m_we_i[3]   = 1'b1;
    bus.s_data_i    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b1000) begin failures++; $display("FAIL unmap_gnt got=%b exp=1000", bus.gnt_o); end
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL unmap_err got=%b exp=1", bus.err_o); end
    checks++; if (bus.m_data_o[3] !== '0) begin failures++; $display("FAIL unmap_data got=%h exp=0", bus.m_data_o[3]); end
    checks++; if (bus.s_we_o !== 3'b000) begin failures++; $display("FAIL unmap_we got=%b exp=000", bus.s_we_o); end
    bus.m_req_i = 4'b0000;
    @(negedge clk); #1;
    checks++; if (bus.err_o !== 1'b0 || bus.gnt_o !== 4'b0000) begin
      failures++; $display("FAIL unmap_end err=%b gnt=%b exp=0/0000", bus.err_o, bus.gnt_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.m_req_i     = 4'b0101;
    bus.m_addr_i[0] = 32'h1000_0000;
    bus.m_we_i[0]   = 1'b1;
    bus.m_addr_i[2] = 32'h2000_0000;
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b0001 || bus.s_we_o !== 3'b010) begin
      failures++; $display("FAIL arst_pre gnt=%b we=%b exp=0001/010", bus.gnt_o, bus.s_we_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.gnt_o !== 4'b0000 || bus.s_we_o !== 3'b000) begin
      failures++; $display("FAIL arst_now gnt=%b we=%b exp=0000/000", bus.gnt_o, bus.s_we_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.m_req_i = 4'b0100;
    #1;
    checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL arst_release gnt=%b exp=0000", bus.gnt_o); end
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL arst_m2 gnt=%b exp=0100", bus.gnt_o); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0]             r;
    logic [AW-1:0]          a;
    int                     sel;
    bit                     frc;
    logic [3:0]             e_gnt;
    logic [2:0][AW-1:0]     e_sa;
    logic [2:0][DW-1:0]     e_sd;
    logic [2:0]             e_we;
    logic [3:0][DW-1:0]     e_md;
    logic                   e_err, e_hold;
    apply_reset();
    mg   = -1;
    mcnt = 0;
    rr_q = {0, 2, 1};
    r    = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(3) == 0) r[n] = ~r[n];
        bus.m_addr_i[n] = {4'($urandom_range(4)), 28'($urandom)};
        bus.m_data_i[n] = $urandom;
        bus.m_we_i[n]   = 1'($urandom_range(1));
      end
      for (int k = 0; k < 3; k++) bus.s_data_i[k] = $urandom;
      bus.m_req_i = r;
      #1;
      e_gnt = (mg < 0) ? 4'b0000 : 4'(1 << mg);
      e_sa = '0; e_sd = '0; e_we = '0; e_md = '0; e_err = 1'b0;
      e_hold = r[1] && (mg != 1);
      if (mg >= 0) begin
        a   = bus.m_addr_i[mg];
        sel = (a[AW-1 -: 4] <= 4'd2) ? int'(a[AW-1 -: 4]) : -1;
        frc = r[mg] && (mcnt >= BM) && (pick(r, mg) >= 0);
        if (sel >= 0) begin
          e_sa[sel] = a;
          e_sd[sel] = bus.m_data_i[mg];
          e_we[sel] = bus.m_we_i[mg] && r[mg] && !frc;
          e_md[mg]  = bus.s_data_i[sel];
        end else begin
          e_err = r[mg];
        end
      end
      checks++; if (bus.gnt_o !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt_o, e_gnt); end
      checks++; if (bus.s_addr_o !== e_sa || bus.s_data_o !== e_sd) begin
        failures++; $display("FAIL rnd_slave_bus cyc=%0d addr=%h data=%h exp_addr=%h exp_data=%h", cyc, bus.s_addr_o, bus.s_data_o, e_sa, e_sd); end
      checks++; if (bus.s_we_o !== e_we) begin failures++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, bus.s_we_o, e_we); end
      checks++; if (bus.m_data_o !== e_md) begin failures++; $display("FAIL rnd_mdata cyc=%0d got=%h exp=%h", cyc, bus.m_data_o, e_md); end
      checks++; if (bus.err_o !== e_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.err_o, e_err); end
      checks++; if (bus.hold_flag_o !== e_hold) begin failures++; $display("FAIL rnd_hold cyc=%0d got=%b exp=%b", cyc, bus.hold_flag_o, e_hold); end
      model_advance(r);
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_m1_read();
    test_m0_write();
    test_burst_limit();
    test_unmapped();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
